// File: rtl/cpu_axi_bridge_pkg.sv
// ---- cpu_axi_bridge_pkg : shared encodings and AXI constants for the CPU-to-AXI3 bridge ----
// ---- rev 1.0                                                                              ----
`default_nettype none

package cpu_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW_W = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

  localparam logic [3:0] AXI_ID_INST    = 4'd0;
  localparam logic [3:0] AXI_ID_DATA    = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;

  // CPU size codes 0/1/2 map directly onto AXI byte/half/word sizes.
  function automatic logic [2:0] cpu_to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_axi_bridge_if.sv
// ---- cpu_axi_bridge_if : SRAM-like CPU request bus and AXI3 master bus ----
// ---- rev 1.0                                                          ----
`default_nettype none

interface cpu_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata
  );
endinterface

interface axi_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
           awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
           wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rvalid, awready, wready, bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
           awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
           wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rvalid, awready, wready, bvalid
  );
endinterface

`default_nettype wire

// File: rtl/cpu_axi_bridge.sv
// ---- cpu_axi_bridge : inst/data SRAM-like ports to one AXI3 master, 1 read + 1 write outstanding ----
// ---- rev 1.0                                                                                      ----
`default_nettype none

module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = AXI_ID_INST,
  parameter logic [3:0] ID_DATA = AXI_ID_DATA
) (
  input  logic  clk,
  input  logic  resetn,
  cpu_if.slave  cpu,
  axi_if.master axi
);

  rd_state_e   rd_state_q, rd_state_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;

  wr_state_e   wr_state_q, wr_state_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic w_rd_idle, w_wr_idle, w_rd_data_busy, w_inst_raw_hazard;
  logic w_data_rd_acc, w_data_wr_acc, w_inst_rd_acc;

  assign w_rd_idle      = (rd_state_q == R_IDLE);
  assign w_wr_idle      = (wr_state_q == W_IDLE);
  assign w_rd_data_busy = !w_rd_idle && (arid_q == ID_DATA);
  // An inst fetch of a word with a write in flight must wait for B, or it could read stale data.
  assign w_inst_raw_hazard = !w_wr_idle && (cpu.inst_addr[31:2] == awaddr_q[31:2]);

  assign w_data_rd_acc = resetn && cpu.data_req && !cpu.data_wr && w_rd_idle && w_wr_idle;
  assign w_data_wr_acc = resetn && cpu.data_req && cpu.data_wr && w_wr_idle && !w_rd_data_busy;
  assign w_inst_rd_acc = resetn && cpu.inst_req && w_rd_idle && !w_data_rd_acc && !w_inst_raw_hazard;

  always_comb begin
    rd_state_d = rd_state_q;
    arid_d     = arid_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    case (rd_state_q)
      R_IDLE: begin
        if (w_data_rd_acc) begin
          rd_state_d = R_AR;
          arid_d     = ID_DATA;
          araddr_d   = cpu.data_addr;
          arsize_d   = cpu_to_axsize(cpu.data_size);
        end else if (w_inst_rd_acc) begin
          rd_state_d = R_AR;
          arid_d     = ID_INST;
          araddr_d   = cpu.inst_addr;
          arsize_d   = AXI_SIZE_WORD;
        end
      end
      R_AR:    if (axi.arready) rd_state_d = R_R;
      R_R:     if (axi.rvalid) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    awaddr_d   = awaddr_q;
    awsize_d   = awsize_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    case (wr_state_q)
      W_IDLE: begin
        if (w_data_wr_acc) begin
          wr_state_d = W_AW_W;
          aw_pend_d  = 1'b1;
          w_pend_d   = 1'b1;
          awaddr_d   = cpu.data_addr;
          awsize_d   = cpu_to_axsize(cpu.data_size);
          wdata_d    = cpu.data_wdata;
          wstrb_d    = cpu.data_wstrb;
        end
      end
      W_AW_W: begin
        if (axi.awready) aw_pend_d = 1'b0;
        if (axi.wready)  w_pend_d  = 1'b0;
        if ((!aw_pend_q || axi.awready) && (!w_pend_q || axi.wready)) wr_state_d = W_B;
      end
      W_B:     if (axi.bvalid) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      arid_q     <= '0;
      araddr_q   <= '0;
      arsize_q   <= '0;
      wr_state_q <= W_IDLE;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      awaddr_q   <= '0;
      awsize_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arid_q     <= arid_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
      wr_state_q <= wr_state_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      awaddr_q   <= awaddr_d;
      awsize_q   <= awsize_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (rd_state_q == R_AR);
  assign axi.rready  = (rd_state_q == R_R);

  assign axi.awid    = ID_DATA;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = aw_pend_q;
  assign axi.wid     = ID_DATA;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_pend_q;
  assign axi.bready  = (wr_state_q == W_B);

  assign cpu.inst_addr_ok = w_inst_rd_acc;
  assign cpu.data_addr_ok = w_data_rd_acc || w_data_wr_acc;
  assign cpu.inst_data_ok = axi.rvalid && axi.rready && (axi.rid == ID_INST);
  assign cpu.data_data_ok = (axi.rvalid && axi.rready && (axi.rid == ID_DATA)) ||
                            (axi.bvalid && axi.bready);
  assign cpu.inst_rdata   = axi.rdata;
  assign cpu.data_rdata   = axi.rdata;

endmodule

`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
// ---- tb_cpu_axi_bridge : directed self-checking bench for cpu_axi_bridge ----
// ---- rev 1.0                                                             ----
`default_nettype none

module tb_cpu_axi_bridge;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_pass;

  cpu_if u_cpu ();
  axi_if u_axi ();

  cpu_axi_bridge #(.ID_INST(4'd0), .ID_DATA(4'd1)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .cpu    (u_cpu),
    .axi    (u_axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle_handshakes(input string tag);
    check({tag, ".arvalid"}, {31'd0, u_axi.arvalid}, 32'd0);
    check({tag, ".rready"},  {31'd0, u_axi.rready},  32'd0);
    check({tag, ".awvalid"}, {31'd0, u_axi.awvalid}, 32'd0);
    check({tag, ".wvalid"},  {31'd0, u_axi.wvalid},  32'd0);
    check({tag, ".bready"},  {31'd0, u_axi.bready},  32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    u_cpu.inst_req = 1'b0; u_cpu.inst_addr = '0;
    u_cpu.data_req = 1'b0; u_cpu.data_wr = 1'b0; u_cpu.data_size = 2'd0;
    u_cpu.data_addr = '0; u_cpu.data_wstrb = '0; u_cpu.data_wdata = '0;
    u_axi.arready = 1'b0; u_axi.rid = '0; u_axi.rdata = '0; u_axi.rvalid = 1'b0;
    u_axi.awready = 1'b0; u_axi.wready = 1'b0; u_axi.bvalid = 1'b0;

    // Reset state
    tick(); #1;
    chk_idle_handshakes("rst");
    check("rst.araddr", u_axi.araddr, 32'h0);
    check("rst.awaddr", u_axi.awaddr, 32'h0);
    check("rst.data_ok", {30'd0, u_cpu.inst_data_ok, u_cpu.data_data_ok}, 32'd0);
    check("const.arburst", {30'd0, u_axi.arburst}, 32'd1);
    check("const.awid_wlast", {27'd0, u_axi.awid, u_axi.wlast}, {27'd0, 4'd1, 1'b1});
    tick(); resetn = 1'b1;

    // 1: inst read with arready held off 3 cycles
    tick(); u_cpu.inst_req = 1'b1; u_cpu.inst_addr = 32'h1C00_0000; #1;
    check("t1.addr_ok", {31'd0, u_cpu.inst_addr_ok}, 32'd1);
    tick(); u_cpu.inst_req = 1'b0; #1;
    check("t1.araddr", u_axi.araddr, 32'h1C00_0000);
    check("t1.arsize", {29'd0, u_axi.arsize}, 32'd2);
    check("t1.arid", {28'd0, u_axi.arid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("t1.arvalid_hold", {31'd0, u_axi.arvalid}, 32'd1);
    end
    u_axi.arready = 1'b1;
    tick(); u_axi.arready = 1'b0; #1;
    check("t1.rready", {30'd0, u_axi.arvalid, u_axi.rready}, 32'd1);
    u_axi.rvalid = 1'b1; u_axi.rid = 4'd0; u_axi.rdata = 32'h0280_0406; #1;
    check("t1.inst_data_ok", {30'd0, u_cpu.inst_data_ok, u_cpu.data_data_ok}, 32'd2);
    check("t1.inst_rdata", u_cpu.inst_rdata, 32'h0280_0406);
    tick(); u_axi.rvalid = 1'b0; #1;
    check("t1.done", {30'd0, u_axi.rready, u_cpu.inst_data_ok}, 32'd0);

    // 2: data read beats inst read in the same cycle
    tick();
    u_cpu.inst_req = 1'b1; u_cpu.inst_addr = 32'h1C00_0004;
    u_cpu.data_req = 1'b1; u_cpu.data_wr = 1'b0; u_cpu.data_addr = 32'h0000_0102; u_cpu.data_size = 2'd1; #1;
    check("t2.arb", {30'd0, u_cpu.data_addr_ok, u_cpu.inst_addr_ok}, 32'd2);
    tick(); u_cpu.data_req = 1'b0; #1;
    check("t2.arid", {28'd0, u_axi.arid}, 32'd1);
    check("t2.araddr", u_axi.araddr, 32'h0000_0102);
    check("t2.arsize", {29'd0, u_axi.arsize}, 32'd1);
    check("t2.inst_wait_ar", {31'd0, u_cpu.inst_addr_ok}, 32'd0);
    u_axi.arready = 1'b1;
    tick(); u_axi.arready = 1'b0;
    u_axi.rvalid = 1'b1; u_axi.rid = 4'd1; u_axi.rdata = 32'hA5A5_0102; #1;
    check("t2.data_ok", {30'd0, u_cpu.data_data_ok, u_cpu.inst_data_ok}, 32'd2);
    check("t2.data_rdata", u_cpu.data_rdata, 32'hA5A5_0102);
    check("t2.inst_wait_r", {31'd0, u_cpu.inst_addr_ok}, 32'd0);
    tick(); u_axi.rvalid = 1'b0; #1;
    check("t2.inst_accept", {31'd0, u_cpu.inst_addr_ok}, 32'd1);
    tick(); u_cpu.inst_req = 1'b0; #1;
    check("t2.inst_ar", {u_axi.araddr[31:4], u_axi.arid}, {28'h1C00_000, 4'd0});
    u_axi.arready = 1'b1;
    tick(); u_axi.arready = 1'b0; u_axi.rvalid = 1'b1; u_axi.rid = 4'd0; u_axi.rdata = 32'h1111_2222; #1;
    check("t2.inst_data_ok", {31'd0, u_cpu.inst_data_ok}, 32'd1);
    tick(); u_axi.rvalid = 1'b0;

    // 3: write, W handshake two cycles ahead of AW
    u_cpu.data_req = 1'b1; u_cpu.data_wr = 1'b1; u_cpu.data_addr = 32'h0000_0100;
    u_cpu.data_size = 2'd1; u_cpu.data_wstrb = 4'b0011; u_cpu.data_wdata = 32'h0000_BEEF; #1;
    check("t3.addr_ok", {31'd0, u_cpu.data_addr_ok}, 32'd1);
    tick(); u_cpu.data_req = 1'b0; #1;
    check("t3.valids", {30'd0, u_axi.awvalid, u_axi.wvalid}, 32'd3);
    check("t3.aw_w", {u_axi.awaddr[15:0], u_axi.wdata[15:0]}, 32'h0100_BEEF);
    check("t3.wstrb_size", {25'd0, u_axi.wstrb, u_axi.awsize}, {25'd0, 4'b0011, 3'd1});
    u_axi.wready = 1'b1;
    tick(); u_axi.wready = 1'b0; #1;
    check("t3.w_dropped", {30'd0, u_axi.awvalid, u_axi.wvalid}, 32'd2);
    tick(); #1;
    check("t3.aw_held", {30'd0, u_axi.awvalid, u_axi.bready}, 32'd2);
    u_axi.awready = 1'b1;
    tick(); u_axi.awready = 1'b0; #1;
    check("t3.in_b", {29'd0, u_axi.awvalid, u_axi.bready, u_cpu.data_data_ok}, 32'd2);
    u_axi.bvalid = 1'b1; #1;
    check("t3.data_ok", {31'd0, u_cpu.data_data_ok}, 32'd1);
    tick(); u_axi.bvalid = 1'b0; #1;
    check("t3.done", {30'd0, u_axi.bready, u_cpu.data_data_ok}, 32'd0);

    // 4: inst fetch vs pending write -- other word goes, same word waits for B
    u_cpu.data_req = 1'b1; u_cpu.data_wr = 1'b1; u_cpu.data_addr = 32'h0000_0100;
    u_cpu.data_size = 2'd2; u_cpu.data_wstrb = 4'hF; u_cpu.data_wdata = 32'h1122_3344; #1;
    check("t4.wr_accept", {31'd0, u_cpu.data_addr_ok}, 32'd1);
    tick(); u_cpu.data_req = 1'b0; u_cpu.inst_req = 1'b1; u_cpu.inst_addr = 32'h0000_0200; #1;
    check("t4.parallel", {30'd0, u_cpu.inst_addr_ok, u_axi.awvalid}, 32'd3);
    tick(); u_cpu.inst_req = 1'b0; #1;
    check("t4.araddr", u_axi.araddr, 32'h0000_0200);
    u_axi.arready = 1'b1;
    tick(); u_axi.arready = 1'b0; u_axi.rvalid = 1'b1; u_axi.rid = 4'd0; u_axi.rdata = 32'h0200_C0DE; #1;
    check("t4.inst_ok", {31'd0, u_cpu.inst_data_ok}, 32'd1);
    tick(); u_axi.rvalid = 1'b0; u_cpu.inst_req = 1'b1; u_cpu.inst_addr = 32'h0000_0100; #1;
    check("t4.raw_block_aw", {31'd0, u_cpu.inst_addr_ok}, 32'd0);
    u_axi.awready = 1'b1; u_axi.wready = 1'b1;
    tick(); u_axi.awready = 1'b0; u_axi.wready = 1'b0; #1;
    check("t4.same_cycle_hs", {29'd0, u_axi.awvalid, u_axi.wvalid, u_axi.bready}, 32'd1);
    u_axi.bvalid = 1'b1; #1;
    check("t4.raw_block_b", {30'd0, u_cpu.inst_addr_ok, u_cpu.data_data_ok}, 32'd1);
    tick(); u_axi.bvalid = 1'b0; #1;
    check("t4.raw_release", {31'd0, u_cpu.inst_addr_ok}, 32'd1);
    tick(); u_cpu.inst_req = 1'b0; #1;
    check("t4.araddr2", u_axi.araddr, 32'h0000_0100);
    u_axi.arready = 1'b1;
    tick(); u_axi.arready = 1'b0; u_axi.rvalid = 1'b1; u_axi.rid = 4'd0; #1;
    check("t4.inst_ok2", {31'd0, u_cpu.inst_data_ok}, 32'd1);
    tick(); u_axi.rvalid = 1'b0;

    // 5: data write waits for an outstanding data read
    u_cpu.data_req = 1'b1; u_cpu.data_wr = 1'b0; u_cpu.data_addr = 32'h0000_0300; u_cpu.data_size = 2'd2; #1;
    check("t5.rd_accept", {31'd0, u_cpu.data_addr_ok}, 32'd1);
    tick(); u_cpu.data_wr = 1'b1; u_cpu.data_addr = 32'h0000_0304; u_cpu.data_wdata = 32'hCAFE_F00D; #1;
    check("t5.wr_block_ar", {30'd0, u_cpu.data_addr_ok, u_axi.arvalid}, 32'd1);
    u_axi.arready = 1'b1;
    tick(); u_axi.arready = 1'b0; u_axi.rvalid = 1'b1; u_axi.rid = 4'd1; u_axi.rdata = 32'h3003_3003; #1;
    check("t5.wr_block_r", {30'd0, u_cpu.data_addr_ok, u_cpu.data_data_ok}, 32'd1);
    tick(); u_axi.rvalid = 1'b0; #1;
    check("t5.wr_accept", {31'd0, u_cpu.data_addr_ok}, 32'd1);
    tick(); u_cpu.data_req = 1'b0; #1;
    check("t5.awaddr", u_axi.awaddr, 32'h0000_0304);

    // 6: reset in the middle of R_R and W_B
    u_axi.awready = 1'b1; u_axi.wready = 1'b1;
    tick(); u_axi.awready = 1'b0; u_axi.wready = 1'b0;
    u_cpu.inst_req = 1'b1; u_cpu.inst_addr = 32'h0000_0400; #1;
    check("t6.inst_accept", {31'd0, u_cpu.inst_addr_ok}, 32'd1);
    tick(); u_cpu.inst_req = 1'b0; u_axi.arready = 1'b1;
    tick(); u_axi.arready = 1'b0; #1;
    check("t6.busy", {30'd0, u_axi.rready, u_axi.bready}, 32'd3);
    u_cpu.inst_req = 1'b1; u_cpu.data_req = 1'b1; u_cpu.data_wr = 1'b0;
    #1 resetn = 1'b0; #1;
    chk_idle_handshakes("t6");
    check("t6.addr_ok", {30'd0, u_cpu.inst_addr_ok, u_cpu.data_addr_ok}, 32'd0);
    check("t6.araddr", u_axi.araddr, 32'h0);
    u_cpu.inst_req = 1'b0; u_cpu.data_req = 1'b0;
    tick(); resetn = 1'b1;
    tick(); #1;
    check("t6.post_idle", {30'd0, u_axi.rready, u_axi.bready}, 32'd0);
    u_cpu.inst_req = 1'b1; u_cpu.inst_addr = 32'h0000_0500; #1;
    check("t6.post_accept", {31'd0, u_cpu.inst_addr_ok}, 32'd1);
    tick(); u_cpu.inst_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
